// File: rtl/coder_deinterleaver.sv
// Streaming LTE turbo QPP deinterleaver: bit-serial fill at pi(i), natural-order drain.
// Optional identity-order debug path is enabled by defining DEINT_BYPASS_EN.
module coder_deinterleaver #(
  parameter int K_SMALL  = 1056,
  parameter int F1_SMALL = 17,
  parameter int F2_SMALL = 66,
  parameter int K_LARGE  = 6144,
  parameter int F1_LARGE = 263,
  parameter int F2_LARGE = 480,
  parameter int ADDR_W   = 13
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  input  logic in_start,
  input  logic K_eq_6144,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last,
  output logic busy
`ifdef DEINT_BYPASS_EN
  ,
  input  logic bypass
`endif
);

  // Both ports use plain valid/ready: a beat transfers on a rising edge where
  // valid and ready are both high; a producer holds its beat until then.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] K_S  = ADDR_W'(K_SMALL);
  localparam logic [ADDR_W-1:0] K_L  = ADDR_W'(K_LARGE);
  localparam logic [ADDR_W-1:0] D_S  = ADDR_W'((2 * F2_SMALL) % K_SMALL);
  localparam logic [ADDR_W-1:0] D_L  = ADDR_W'((2 * F2_LARGE) % K_LARGE);
  localparam logic [ADDR_W-1:0] G0_S = ADDR_W'((F1_SMALL + F2_SMALL) % K_SMALL);
  localparam logic [ADDR_W-1:0] G0_L = ADDR_W'((F1_LARGE + F2_LARGE) % K_LARGE);
  localparam logic [ADDR_W-1:0] G1_S = ADDR_W'((F1_SMALL + 3 * F2_SMALL) % K_SMALL);
  localparam logic [ADDR_W-1:0] G1_L = ADDR_W'((F1_LARGE + 3 * F2_LARGE) % K_LARGE);

  function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b,
                                                input logic [ADDR_W-1:0] k);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, k}) ? ADDR_W'(s - {1'b0, k}) : ADDR_W'(s);
  endfunction

  logic [1:0]        state_q, state_d;
  logic              k_large_q, k_large_d;
  logic              bypass_q, bypass_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] pi_q, pi_d;
  logic [ADDR_W-1:0] g_q, g_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              issued_all_q, issued_all_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              rd_data_q;
  logic              out_valid_q, out_valid_d;
  logic              out_bit_q, out_bit_d;
  logic              out_last_q, out_last_d;

  logic              mem [0:K_LARGE-1];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic              mem_re;

  logic              bypass_in;
  logic              accept;
  logic              advance;
  logic              s1_load;
  logic              issue;
  logic [ADDR_W-1:0] k_cur, d_cur, g0_new, g1_new;

`ifdef DEINT_BYPASS_EN
  assign bypass_in = bypass;
`else
  assign bypass_in = 1'b0;
`endif

  assign k_cur   = k_large_q ? K_L : K_S;
  assign d_cur   = k_large_q ? D_L : D_S;
  assign g0_new  = K_eq_6144 ? G0_L : G0_S;
  assign g1_new  = K_eq_6144 ? G1_L : G1_S;
  assign accept  = in_valid & in_ready_q;

  // Two-stage read pipeline: RAM data register, then output register.
  assign advance = ~out_valid_q | out_ready;
  assign s1_load = advance | ~rd_valid_q;
  assign issue   = (state_q == S_DRAIN) & ~issued_all_q & s1_load;

  always_comb begin
    state_d      = state_q;
    k_large_d    = k_large_q;
    bypass_d     = bypass_q;
    i_d          = i_q;
    pi_d         = pi_q;
    g_d          = g_q;
    rd_addr_d    = rd_addr_q;
    issued_all_d = issued_all_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    out_valid_d  = out_valid_q;
    out_bit_d    = out_bit_q;
    out_last_d   = out_last_q;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_re       = 1'b0;

    case (state_q)
      S_IDLE, S_FILL: begin
        if (accept) begin
          if (in_start) begin
            // i=0 always lands at address 0; preload pi(1) and g(1).
            mem_we    = 1'b1;
            mem_waddr = '0;
            k_large_d = K_eq_6144;
            bypass_d  = bypass_in;
            i_d       = ADDR_W'(1);
            pi_d      = g0_new;
            g_d       = g1_new;
            state_d   = S_FILL;
          end else if (state_q == S_FILL) begin
            mem_we    = 1'b1;
            mem_waddr = bypass_q ? i_q : pi_q;
            i_d       = i_q + 1'b1;
            pi_d      = mod_add(pi_q, g_q, k_cur);
            g_d       = mod_add(g_q, d_cur, k_cur);
            if (i_q == k_cur - 1'b1) begin
              state_d = S_DRAIN;
            end
          end
        end
      end

      S_DRAIN: begin
        if (advance) begin
          out_valid_d = rd_valid_q;
          out_last_d  = rd_last_q;
          if (rd_valid_q) begin
            out_bit_d = rd_data_q;
          end
        end
        if (s1_load) begin
          rd_valid_d = issue;
          rd_last_d  = issue & (rd_addr_q == k_cur - 1'b1);
        end
        if (issue) begin
          mem_re    = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          if (rd_addr_q == k_cur - 1'b1) begin
            issued_all_d = 1'b1;
          end
        end
        if (out_valid_q & out_ready & out_last_q) begin
          state_d      = S_IDLE;
          rd_addr_d    = '0;
          issued_all_d = 1'b0;
          rd_valid_d   = 1'b0;
          rd_last_d    = 1'b0;
          out_valid_d  = 1'b0;
          out_bit_d    = 1'b0;
          out_last_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d != S_DRAIN);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      k_large_q    <= 1'b0;
      bypass_q     <= 1'b0;
      i_q          <= '0;
      pi_q         <= '0;
      g_q          <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      rd_addr_q    <= '0;
      issued_all_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_large_q    <= k_large_d;
      bypass_q     <= bypass_d;
      i_q          <= i_d;
      pi_q         <= pi_d;
      g_q          <= g_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      rd_addr_q    <= rd_addr_d;
      issued_all_q <= issued_all_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      out_valid_q  <= out_valid_d;
      out_bit_q    <= out_bit_d;
      out_last_q   <= out_last_d;
    end
  end

  // Block buffer has no reset; reads and writes never overlap in time.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= in_bit;
    end
    if (mem_re) begin
      rd_data_q <= mem[rd_addr_q];
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;

endmodule
